// File: rtl/mips_int_ctrl_pkg.sv
// Shared types and constants for the MIPS interrupt controller:
// FSM states, register map, MASK/CAUSE bit positions and the priority encoder.
package mips_int_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [1:0]  ADDR_MASK       = 2'd0;
  localparam logic [1:0]  ADDR_PENDING    = 2'd1;
  localparam logic [1:0]  ADDR_CAUSE      = 2'd2;
  localparam int unsigned GIE_BIT         = 8;
  localparam int unsigned CAUSE_VALID_BIT = 3;
  localparam int unsigned NEST_DEPTH      = 4;

  // Fixed priority: the highest set index wins.
  function automatic logic [2:0] top_id(input logic [7:0] v);
    top_id = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (v[i]) top_id = 3'(i);
    end
  endfunction

endpackage

// File: rtl/mips_int_ctrl_if.sv
// Core-side register bus and exception handshake of the interrupt controller.
interface mips_int_ctrl_if;
  logic        reg_we;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        irq_req;
  logic [31:0] irq_vec;
  logic        irq_ack;
  logic        eret;

  modport master (output reg_we, reg_addr, reg_wdata, irq_ack, eret,
                  input  reg_rdata, irq_req, irq_vec);
  modport slave  (input  reg_we, reg_addr, reg_wdata, irq_ack, eret,
                  output reg_rdata, irq_req, irq_vec);
endinterface

// File: rtl/mips_int_ctrl_sync_edge.sv
// Per-line synchronizer chain followed by a rising-edge pulse detector.
module int_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/mips_int_ctrl.sv
// MIPS interrupt controller top: pending/mask registers, priority grant, request FSM.
// Define NESTED_IRQ_EN to allow higher-priority preemption with a 4-deep in-service stack.
module mips_int_ctrl
  import mips_int_pkg::*;
#(
  parameter int unsigned N_IRQ       = 5,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] VEC_BASE    = 32'h0000_0180,
  parameter logic [31:0] VEC_STRIDE  = 32'h0000_0020
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] int_in,
  mips_int_ctrl_if.slave   bus
);
  logic [N_IRQ-1:0] edge_pulse, pending_q, mask_q, eligible, ack_clr, w1c_clr;
  logic [7:0]       elig8;
  logic             gie_q, svc_valid_q, svc_valid_d, irq_req_q;
  logic [2:0]       top, gnt_q, gnt_d, svc_id_q, svc_id_d;
  logic [31:0]      irq_vec_q;
  state_t           state_q, state_d;
`ifdef NESTED_IRQ_EN
  logic             preempt_q, preempt_d, push, pop;
  logic [2:0]       depth_q;
  logic [2:0]       stk_q [NEST_DEPTH];
`endif

  for (genvar i = 0; i < N_IRQ; i++) begin : gen_sync
    int_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk(clk), .rst(rst), .din(int_in[i]), .pulse(edge_pulse[i])
    );
  end

  assign eligible = pending_q & mask_q & {N_IRQ{gie_q}};
  assign elig8    = 8'(eligible);
  assign top      = top_id(elig8);
  assign w1c_clr  = (bus.reg_we && bus.reg_addr == ADDR_PENDING) ? bus.reg_wdata[N_IRQ-1:0] : '0;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    svc_id_d    = svc_id_q;
    svc_valid_d = svc_valid_q;
    ack_clr     = '0;
`ifdef NESTED_IRQ_EN
    preempt_d   = preempt_q;
    push        = 1'b0;
    pop         = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (eligible != '0) begin
          state_d = REQ;
          gnt_d   = top;
        end
      end
      REQ: begin
        if (!elig8[gnt_q]) begin
`ifdef NESTED_IRQ_EN
          // A withdrawn preemption falls back to the interrupted handler.
          state_d   = preempt_q ? SERVICE : IDLE;
          preempt_d = 1'b0;
`else
          state_d = IDLE;
`endif
        end else if (bus.irq_ack) begin
          state_d     = SERVICE;
          ack_clr     = N_IRQ'(8'd1 << gnt_q);
          svc_id_d    = gnt_q;
          svc_valid_d = 1'b1;
`ifdef NESTED_IRQ_EN
          push        = preempt_q;
          preempt_d   = 1'b0;
`endif
        end else begin
          gnt_d = top;
        end
      end
      SERVICE: begin
        if (bus.eret) begin
`ifdef NESTED_IRQ_EN
          if (depth_q != '0) begin
            pop      = 1'b1;
            svc_id_d = stk_q[2'(depth_q - 3'd1)];
          end else begin
            state_d     = IDLE;
            svc_id_d    = '0;
            svc_valid_d = 1'b0;
          end
        end else if (eligible != '0 && top > svc_id_q && depth_q != 3'(NEST_DEPTH)) begin
          state_d   = REQ;
          gnt_d     = top;
          preempt_d = 1'b1;
`else
          state_d     = IDLE;
          svc_id_d    = '0;
          svc_valid_d = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      svc_id_q    <= '0;
      svc_valid_q <= 1'b0;
      irq_req_q   <= 1'b0;
      irq_vec_q   <= VEC_BASE;
      pending_q   <= '0;
      mask_q      <= '0;
      gie_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      svc_id_q    <= svc_id_d;
      svc_valid_q <= svc_valid_d;
      irq_req_q   <= (state_d == REQ);
      irq_vec_q   <= VEC_BASE + 32'(gnt_d) * VEC_STRIDE;
      // New edges override any clear in the same cycle.
      pending_q   <= (pending_q & ~(ack_clr | w1c_clr)) | edge_pulse;
      if (bus.reg_we && bus.reg_addr == ADDR_MASK) begin
        mask_q <= bus.reg_wdata[N_IRQ-1:0];
        gie_q  <= bus.reg_wdata[GIE_BIT];
      end
    end
  end

`ifdef NESTED_IRQ_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      preempt_q <= 1'b0;
      depth_q   <= '0;
      for (int unsigned i = 0; i < NEST_DEPTH; i++) stk_q[i] <= '0;
    end else begin
      preempt_q <= preempt_d;
      if (push) begin
        stk_q[depth_q[1:0]] <= svc_id_q;
        depth_q             <= depth_q + 3'd1;
      end else if (pop) begin
        depth_q <= depth_q - 3'd1;
      end
    end
  end
`endif

  always_comb begin
    bus.reg_rdata = '0;
    case (bus.reg_addr)
      ADDR_MASK: begin
        bus.reg_rdata[N_IRQ-1:0] = mask_q;
        bus.reg_rdata[GIE_BIT]   = gie_q;
      end
      ADDR_PENDING: bus.reg_rdata[N_IRQ-1:0] = pending_q;
      ADDR_CAUSE: begin
        bus.reg_rdata[2:0]             = svc_id_q;
        bus.reg_rdata[CAUSE_VALID_BIT] = svc_valid_q;
      end
      default: ;
    endcase
  end

  assign bus.irq_req = irq_req_q;
  assign bus.irq_vec = irq_vec_q;
endmodule
